// File: rtl/sha256_pkg.sv
// Shared SHA-256 sequencing types and constants: sequencer states,
// block geometry and the initial hash value the core resets to.
`timescale 1ns/1ps
package sha256_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_FILL,
    S_GO,
    S_WAIT,
    S_OUT
  } seq_state_t;

  localparam int SHA256_WORDS    = 16;
  localparam int SHA256_DIGEST_W = 256;

  localparam logic [SHA256_DIGEST_W-1:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

endpackage

// File: rtl/sha256_done_edge.sv
// Completion detector for the compression core: registers the previous done
// level so a level left high from an earlier block is not taken as completion.
`timescale 1ns/1ps
module sha256_done_edge
  import sha256_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic core_done,
  output logic done_rise
);

  logic done_prev;

  // Reset to 1 so a done level present straight out of reset never counts.
  always_ff @(posedge clk) begin
    if (!reset) done_prev <= 1'b1;
    else        done_prev <= core_done;
  end

  assign done_rise = core_done && !done_prev;

endmodule

// File: rtl/sha256_block_sequencer.sv
// Feeds pre-padded 512-bit blocks into the SHA-256 compression core, chains
// blocks of one message and returns the digest. SHA_WDOG_EN adds a WAIT watchdog.
`timescale 1ns/1ps
module sha256_block_sequencer
  import sha256_pkg::*;
#(
  parameter int WDOG_CYCLES = 128,
  parameter int BLK_CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [31:0]                in_data,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic                       digest_valid,
  output logic [SHA256_DIGEST_W-1:0] digest,
  input  logic                       digest_ready,
  output logic                       err,
  output logic                       busy,
  output logic [BLK_CNT_W-1:0]       blocks_done,
  output logic                       core_reset,
  output logic                       core_chipselect,
  output logic                       core_write,
  output logic [3:0]                 core_address,
  output logic [31:0]                core_writedata,
  output logic                       core_go,
  input  logic [SHA256_DIGEST_W-1:0] core_h,
  input  logic                       core_done
);

  seq_state_t state;
  logic [3:0] idx;
  logic       last_q;
  logic       core_reset_q;
  logic       done_rise;
  logic       accept;
  logic       bad_last;
  logic       wdog_fire;

  sha256_done_edge u_done_edge (
    .clk       (clk),
    .reset     (reset),
    .core_done (core_done),
    .done_rise (done_rise)
  );

  assign in_ready        = (state == S_FILL);
  assign busy            = (state != S_IDLE);
  assign accept          = in_valid && in_ready;
  assign bad_last        = in_last && (idx != 4'(SHA256_WORDS - 1));
  assign core_chipselect = accept && !bad_last;
  assign core_write      = core_chipselect;
  assign core_address    = idx;
  assign core_writedata  = in_data;
  assign core_reset      = core_reset_q || !reset;

`ifdef SHA_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt;

  // Counts cycles since GO; value k means GO was k cycles ago.
  always_ff @(posedge clk) begin
    if (!reset || (state != S_GO && state != S_WAIT)) wdog_cnt <= '0;
    else                                              wdog_cnt <= wdog_cnt + 1'b1;
  end

  assign wdog_fire = (state == S_WAIT) && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
`else
  logic [31:0] unused_wdog_cfg;
  assign unused_wdog_cfg = WDOG_CYCLES;
  assign wdog_fire       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      last_q       <= 1'b0;
      blocks_done  <= '0;
      digest_valid <= 1'b0;
      digest       <= '0;
      err          <= 1'b0;
      core_go      <= 1'b0;
      core_reset_q <= 1'b0;
    end else begin
      err          <= 1'b0;
      core_go      <= 1'b0;
      core_reset_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            core_reset_q <= 1'b1;
            state        <= S_INIT;
          end
        end
        S_INIT: begin
          idx   <= '0;
          state <= S_FILL;
        end
        S_FILL: begin
          if (accept) begin
            if (bad_last) begin
              // Early in_last: drop the word and restart the message from the IV.
              err          <= 1'b1;
              core_reset_q <= 1'b1;
              idx          <= '0;
              state        <= S_INIT;
            end else begin
              idx <= idx + 1'b1;
              if (idx == 4'(SHA256_WORDS - 1)) begin
                last_q  <= in_last;
                core_go <= 1'b1;
                state   <= S_GO;
              end
            end
          end
        end
        S_GO: state <= S_WAIT;
        S_WAIT: begin
          if (done_rise) begin
            blocks_done <= blocks_done + 1'b1;
            if (last_q) begin
              digest       <= core_h;
              digest_valid <= 1'b1;
              state        <= S_OUT;
            end else begin
              state <= S_FILL;
            end
          end else if (wdog_fire) begin
            err          <= 1'b1;
            core_reset_q <= 1'b1;
            state        <= S_IDLE;
          end
        end
        S_OUT: begin
          if (digest_ready) begin
            digest_valid <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Bench for sha256_block_sequencer: behavioural SHA-256 core stub plus a
// whole-message reference digest, known vectors and randomized messages.
`timescale 1ns/1ps
module tb_sha256_block_sequencer;

  localparam int BLK_CNT_W   = 16;
  localparam int WDOG_CYCLES = 128;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] TWO_DIGEST =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic [31:0] in_data = '0;
  logic digest_ready = 1'b0;
  logic in_ready, digest_valid, err, busy;
  logic [255:0] digest;
  logic [BLK_CNT_W-1:0] blocks_done;
  logic core_reset, core_chipselect, core_write, core_go;
  logic [3:0] core_address;
  logic [31:0] core_writedata;
  logic [255:0] core_h;
  logic core_done;

  always #5 clk = ~clk;

  sha256_block_sequencer #(
    .WDOG_CYCLES (WDOG_CYCLES),
    .BLK_CNT_W   (BLK_CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_last         (in_last),
    .in_ready        (in_ready),
    .digest_valid    (digest_valid),
    .digest          (digest),
    .digest_ready    (digest_ready),
    .err             (err),
    .busy            (busy),
    .blocks_done     (blocks_done),
    .core_reset      (core_reset),
    .core_chipselect (core_chipselect),
    .core_write      (core_write),
    .core_address    (core_address),
    .core_writedata  (core_writedata),
    .core_go         (core_go),
    .core_h          (core_h),
    .core_done       (core_done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_blocks = 0;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [31:0] blk [16]);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = blk[t];
    for (int t = 16; t < 64; t++)
      w[t] = w[t-16] + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3))
           + w[t-7] + (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10));
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Digest of a whole padded message: chain every 16-word block from the IV.
  function automatic logic [255:0] sha_ref(input logic [31:0] m [$]);
    logic [255:0] hv;
    logic [31:0] blk [16];
    hv = IV;
    for (int bi = 0; bi < m.size() / 16; bi++) begin
      for (int i = 0; i < 16; i++) blk[i] = m[bi*16 + i];
      hv = sha_compress(hv, blk);
    end
    return hv;
  endfunction

  // Compression core stub: write port, reset to IV, done rises core_lat cycles after go.
  logic [31:0] cmem [16];
  int core_cnt = 0;
  int core_lat = 5;
  bit core_stall = 1'b0;

  always @(posedge clk) begin
    if (core_reset) begin
      core_h    <= IV;
      core_done <= 1'b0;
      core_cnt  <= 0;
    end else begin
      if (core_chipselect && core_write) cmem[core_address] <= core_writedata;
      if (core_go) begin
        core_done <= 1'b0;
        core_cnt  <= core_lat;
      end else if (core_cnt > 0) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1 && !core_stall) begin
          core_h    <= sha_compress(core_h, cmem);
          core_done <= 1'b1;
        end
      end
    end
  end

  int cyc = 0, cr_cnt = 0, err_cnt = 0, go_cyc = 0, dv_cyc = 0, fill_cyc = 0;
  logic dv_prev = 1'b0, ir_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (core_reset) cr_cnt++;
      if (err) err_cnt++;
    end
    if (core_go) go_cyc = cyc;
    if (digest_valid && !dv_prev) dv_cyc = cyc;
    if (in_ready && !ir_prev) fill_cyc = cyc;
    dv_prev = digest_valid;
    ir_prev = in_ready;
  end

  logic [31:0] abc_q [$];
  logic [31:0] two_q [$];

  task automatic send_word(input logic [31:0] d, input logic last);
    int t;
    in_valid = 1'b1; in_data = d; in_last = last;
    t = 0;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, t);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_msg(input logic [31:0] m [$]);
    for (int i = 0; i < m.size(); i++) send_word(m[i], i == m.size() - 1);
  endtask

  task automatic wait_digest(output logic [255:0] d, output bit ok);
    int t;
    t = 0;
    while (!digest_valid && t < 3000) begin
      @(negedge clk);
      t++;
    end
    ok = digest_valid;
    d  = digest;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_checks++; if (digest_valid !== 1'b0) begin n_fail++; $display("FAIL rst_digest_valid: got %b want 0", digest_valid); end
    n_checks++; if (digest !== 256'd0) begin n_fail++; $display("FAIL rst_digest: got %h want 0", digest); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    n_checks++; if (core_go !== 1'b0) begin n_fail++; $display("FAIL rst_core_go: got %b want 0", core_go); end
    n_checks++; if (core_write !== 1'b0) begin n_fail++; $display("FAIL rst_core_write: got %b want 0", core_write); end
    n_checks++; if (core_reset !== 1'b1) begin n_fail++; $display("FAIL rst_core_reset: got %b want 1", core_reset); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (blocks_done !== '0) begin n_fail++; $display("FAIL rst_blocks_done: got %0d want 0", blocks_done); end
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (core_reset !== 1'b0) begin n_fail++; $display("FAIL rst_release_core_reset: got %b want 0", core_reset); end
    exp_blocks = 0;
  endtask

  task automatic test_abc;
    logic [255:0] d;
    bit ok;
    core_lat = 7;
    send_msg(abc_q);
    wait_digest(d, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL abc_timeout: digest_valid=%b want 1", digest_valid); end
    n_checks++; if (d !== ABC_DIGEST) begin n_fail++; $display("FAIL abc_digest: got %h want %h", d, ABC_DIGEST); end
    exp_blocks++;
    n_checks++; if (blocks_done !== BLK_CNT_W'(exp_blocks)) begin n_fail++; $display("FAIL abc_blocks: got %0d want %0d", blocks_done, exp_blocks); end
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    n_checks++; if (go_cyc - fill_cyc !== 16) begin n_fail++; $display("FAIL abc_fill_len: got %0d want 16", go_cyc - fill_cyc); end
    n_checks++; if (dv_cyc - go_cyc !== core_lat + 2) begin n_fail++; $display("FAIL abc_latency: got %0d want %0d", dv_cyc - go_cyc, core_lat + 2); end
    n_checks++; if (digest_valid !== 1'b0) begin n_fail++; $display("FAIL abc_accept_valid: got %b want 0", digest_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abc_accept_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_two_block;
    logic [255:0] d;
    bit ok;
    int cr0;
    cr0 = cr_cnt;
    core_lat = 4;
    send_msg(two_q);
    wait_digest(d, ok);
    n_checks++; if (!ok || d !== TWO_DIGEST) begin n_fail++; $display("FAIL two_digest: got %h want %h", d, TWO_DIGEST); end
    exp_blocks += 2;
    n_checks++; if (blocks_done !== BLK_CNT_W'(exp_blocks)) begin n_fail++; $display("FAIL two_blocks: got %0d want %0d", blocks_done, exp_blocks); end
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    n_checks++; if (cr_cnt - cr0 !== 1) begin n_fail++; $display("FAIL two_init_pulses: got %0d want 1", cr_cnt - cr0); end
    send_msg(abc_q);
    wait_digest(d, ok);
    n_checks++; if (!ok || d !== ABC_DIGEST) begin n_fail++; $display("FAIL reinit_abc: got %h want %h", d, ABC_DIGEST); end
    exp_blocks++;
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [31:0] m1 [$];
    logic [31:0] m2 [$];
    logic [255:0] d;
    bit ok;
    int init_k;
    for (int i = 0; i < 16; i++) begin m1.push_back($urandom); m2.push_back($urandom); end
    core_lat = $urandom_range(2, 12);
    send_msg(m1);
    wait_digest(d, ok);
    n_checks++; if (!ok || d !== sha_ref(m1)) begin n_fail++; $display("FAIL bp_first_digest: got %h want %h", d, sha_ref(m1)); end
    exp_blocks++;
    in_valid = 1'b1; in_data = m2[0]; in_last = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_checks++; if (digest !== d || digest_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold c%0d: digest=%h valid=%b want %h 1", c, digest, digest_valid, d); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, in_ready); end
    end
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    init_k = 0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      if (core_reset && init_k == 0) init_k = k;
    end
    n_checks++; if (init_k == 0) begin n_fail++; $display("FAIL bp_next_init: core_reset not seen within 2 cycles, want 1"); end
    send_msg(m2);
    wait_digest(d, ok);
    n_checks++; if (!ok || d !== sha_ref(m2)) begin n_fail++; $display("FAIL bp_second_digest: got %h want %h", d, sha_ref(m2)); end
    exp_blocks++;
    n_checks++; if (blocks_done !== BLK_CNT_W'(exp_blocks)) begin n_fail++; $display("FAIL bp_blocks: got %0d want %0d", blocks_done, exp_blocks); end
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
  endtask

  task automatic test_early_last;
    logic [255:0] d;
    bit ok;
    int err0, cr0;
    err0 = err_cnt; cr0 = cr_cnt;
    for (int i = 0; i < 7; i++) send_word($urandom, 1'b0);
    send_word($urandom, 1'b1);
    repeat (3) @(negedge clk);
    n_checks++; if (err_cnt - err0 !== 1) begin n_fail++; $display("FAIL early_err_pulses: got %0d want 1", err_cnt - err0); end
    n_checks++; if (cr_cnt - cr0 !== 2) begin n_fail++; $display("FAIL early_core_reset: got %0d cycles want 2", cr_cnt - cr0); end
    n_checks++; if (digest_valid !== 1'b0) begin n_fail++; $display("FAIL early_no_digest: got %b want 0", digest_valid); end
    n_checks++; if (blocks_done !== BLK_CNT_W'(exp_blocks)) begin n_fail++; $display("FAIL early_blocks: got %0d want %0d", blocks_done, exp_blocks); end
    send_msg(abc_q);
    wait_digest(d, ok);
    n_checks++; if (!ok || d !== ABC_DIGEST) begin n_fail++; $display("FAIL early_recover_abc: got %h want %h", d, ABC_DIGEST); end
    exp_blocks++;
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [255:0] d;
    bit ok;
    int t;
    core_lat = 40;
    send_msg(abc_q);
    t = 0;
    while (!core_go && t < 20) begin @(negedge clk); t++; end
    n_checks++; if (!core_go) begin n_fail++; $display("FAIL midrst_go: core_go=%b want 1", core_go); end
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_checks++; if (digest_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", digest_valid); end
    n_checks++; if (blocks_done !== '0) begin n_fail++; $display("FAIL midrst_blocks: got %0d want 0", blocks_done); end
    reset = 1'b1;
    exp_blocks = 0;
    core_lat = 6;
    @(negedge clk);
    send_msg(abc_q);
    wait_digest(d, ok);
    n_checks++; if (!ok || d !== ABC_DIGEST) begin n_fail++; $display("FAIL midrst_abc: got %h want %h", d, ABC_DIGEST); end
    exp_blocks++;
    n_checks++; if (blocks_done !== BLK_CNT_W'(exp_blocks)) begin n_fail++; $display("FAIL midrst_blocks_after: got %0d want %0d", blocks_done, exp_blocks); end
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
  endtask

  task automatic test_watchdog;
    int t, k, bad;
    core_stall = 1'b1;
    core_lat = 5;
    send_msg(abc_q);
    t = 0;
    while (!core_go && t < 20) begin @(negedge clk); t++; end
    n_checks++; if (!core_go) begin n_fail++; $display("FAIL wdog_go: core_go=%b want 1", core_go); end
`ifdef SHA_WDOG_EN
    k = 0;
    while (!err && k < 1200) begin @(negedge clk); k++; end
    n_checks++; if (k !== WDOG_CYCLES) begin n_fail++; $display("FAIL wdog_err_time: got %0d cycles want %0d", k, WDOG_CYCLES); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wdog_idle: busy=%b want 0", busy); end
    n_checks++; if (digest_valid !== 1'b0 || blocks_done !== BLK_CNT_W'(exp_blocks)) begin
      n_fail++; $display("FAIL wdog_no_digest: valid=%b blocks=%0d want 0 %0d", digest_valid, blocks_done, exp_blocks);
    end
`else
    bad = 0;
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (err || !busy || digest_valid) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL wait_unbounded: %0d bad cycles want 0", bad); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_blocks = 0;
    @(negedge clk);
`endif
    core_stall = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] m [$];
    logic [255:0] d;
    bit ok;
    int nblk;
    for (int n = 0; n < 6; n++) begin
      m.delete();
      nblk = $urandom_range(1, 3);
      for (int i = 0; i < nblk * 16; i++) m.push_back($urandom);
      core_lat = $urandom_range(2, 25);
      digest_ready = 1'($urandom_range(0, 1));
      send_msg(m);
      wait_digest(d, ok);
      n_checks++; if (!ok || d !== sha_ref(m)) begin n_fail++; $display("FAIL rand_digest n%0d: got %h want %h", n, d, sha_ref(m)); end
      exp_blocks += nblk;
      n_checks++; if (blocks_done !== BLK_CNT_W'(exp_blocks)) begin n_fail++; $display("FAIL rand_blocks n%0d: got %0d want %0d", n, blocks_done, exp_blocks); end
      digest_ready = 1'b1;
      @(negedge clk);
      digest_ready = 1'b0;
      n_checks++; if (digest_valid !== 1'b0) begin n_fail++; $display("FAIL rand_accept n%0d: valid=%b want 0", n, digest_valid); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    abc_q.push_back(32'h61626380);
    for (int i = 1; i < 15; i++) abc_q.push_back(32'h0);
    abc_q.push_back(32'h00000018);
    two_q = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
              32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
              32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
              32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    for (int i = 0; i < 15; i++) two_q.push_back(32'h0);
    two_q.push_back(32'h000001c0);

    test_reset();
    test_abc();
    test_two_block();
    test_backpressure();
    test_early_last();
    test_reset_mid();
    test_watchdog();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
